// File: rtl/beta_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beta_if_stage : instruction fetch stage (PC, req/gnt/rvalid fetch,    |
// |                 redirect handling, delivery to decode)               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module beta_if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  input  logic                  if_branch_taken_i,
  input  logic [DATA_WIDTH-1:0] if_branch_target_i,
  input  logic                  dec_stage_busy_i,
  output logic [31:0]           if_instr_o,
  output logic [DATA_WIDTH-1:0] if_pc_o,
  output logic [DATA_WIDTH-1:0] if_next_pc_o,
  output logic                  if_new_instr_o,
  output logic                  if_stage_busy_o,
  output logic [31:0]           if_fetch_count_o
);

  localparam logic [31:0]           c_nop_instr  = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] c_pc_step    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] c_align_mask = DATA_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_HOLD    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]           instr_q, instr_d;
  logic                  redir_q, redir_d;
  logic [DATA_WIDTH-1:0] redir_tgt_q, redir_tgt_d;
  logic                  discard_q, discard_d;
  logic [31:0]           count_q, count_d;
  logic                  req_q, req_d;
  logic                  new_instr_q, new_instr_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] w_tgt_in;
  logic [DATA_WIDTH-1:0] w_pc_plus4;

  assign w_tgt_in   = if_branch_target_i & ~c_align_mask;
  assign w_pc_plus4 = pc_q + c_pc_step;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    instr_d     = instr_q;
    redir_d     = redir_q;
    redir_tgt_d = redir_tgt_q;
    discard_d   = discard_q;
    count_d     = count_q;

    if (if_branch_taken_i) begin
      redir_d     = 1'b1;
      redir_tgt_d = w_tgt_in;
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (if_branch_taken_i) discard_d = 1'b1;
        if (imem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (if_branch_taken_i) discard_d = 1'b1;
        if (imem_rvalid_i) begin
          // A redirect arriving with the data still kills it; newest target wins.
          if (discard_q || if_branch_taken_i) begin
            pc_d      = if_branch_taken_i ? w_tgt_in : redir_tgt_q;
            redir_d   = 1'b0;
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            instr_d = imem_rdata_i;
            if_pc_d = pc_q;
            state_d = S_DELIVER;
          end
        end
      end
      S_DELIVER: begin
        count_d = count_q + 32'd1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!dec_stage_busy_i) begin
          if (if_branch_taken_i) pc_d = w_tgt_in;
          else if (redir_q)      pc_d = redir_tgt_q;
          else                   pc_d = w_pc_plus4;
          redir_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d       = (state_d == S_REQ);
    new_instr_d = (state_d == S_DELIVER);
    busy_d      = (state_d == S_REQ) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= BOOT_ADDR;
      if_pc_q     <= BOOT_ADDR;
      instr_q     <= c_nop_instr;
      redir_q     <= 1'b0;
      redir_tgt_q <= '0;
      discard_q   <= 1'b0;
      count_q     <= '0;
      req_q       <= 1'b0;
      new_instr_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      instr_q     <= instr_d;
      redir_q     <= redir_d;
      redir_tgt_q <= redir_tgt_d;
      discard_q   <= discard_d;
      count_q     <= count_d;
      req_q       <= req_d;
      new_instr_q <= new_instr_d;
      busy_q      <= busy_d;
    end
  end

  assign imem_req_o       = req_q;
  assign imem_addr_o      = pc_q;
  assign if_instr_o       = instr_q;
  assign if_pc_o          = if_pc_q;
  assign if_next_pc_o     = if_pc_q + c_pc_step;
  assign if_new_instr_o   = new_instr_q;
  assign if_stage_busy_o  = busy_q;
  assign if_fetch_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_beta_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_beta_if_stage : directed self-checking bench for beta_if_stage    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_beta_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_branch_taken_i = 1'b0;
  logic [31:0] if_branch_target_i = '0;
  logic        dec_stage_busy_i = 1'b0;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_next_pc_o;
  logic        if_new_instr_o;
  logic        if_stage_busy_o;
  logic [31:0] if_fetch_count_o;

  int checks   = 0;
  int failures = 0;

  beta_if_stage dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .imem_req_o         (imem_req_o),
    .imem_addr_o        (imem_addr_o),
    .imem_gnt_i         (imem_gnt_i),
    .imem_rvalid_i      (imem_rvalid_i),
    .imem_rdata_i       (imem_rdata_i),
    .if_branch_taken_i  (if_branch_taken_i),
    .if_branch_target_i (if_branch_target_i),
    .dec_stage_busy_i   (dec_stage_busy_i),
    .if_instr_o         (if_instr_o),
    .if_pc_o            (if_pc_o),
    .if_next_pc_o       (if_next_pc_o),
    .if_new_instr_o     (if_new_instr_o),
    .if_stage_busy_o    (if_stage_busy_o),
    .if_fetch_count_o   (if_fetch_count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (!imem_req_o && n < max_cycles) begin
      step();
      n++;
    end
    chk("req_rise", {31'd0, imem_req_o}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_req",   {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr",  imem_addr_o, 32'h0);
    chk("rst_instr", if_instr_o, 32'h0000_0013);
    chk("rst_pc",    if_pc_o, 32'h0);
    chk("rst_npc",   if_next_pc_o, 32'h4);
    chk("rst_new",   {31'd0, if_new_instr_o}, 32'd0);
    chk("rst_busy",  {31'd0, if_stage_busy_o}, 32'd0);
    chk("rst_cnt",   if_fetch_count_o, 32'd0);

    // Basic fetch: gnt same cycle, rvalid one cycle later
    rst = 1'b0;
    wait_req(4);
    chk("t1_addr", imem_addr_o, 32'h0);
    chk("t1_busy", {31'd0, if_stage_busy_o}, 32'd1);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk("t1_req_drop", {31'd0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
    step();
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    chk("t1_new",   {31'd0, if_new_instr_o}, 32'd1);
    chk("t1_instr", if_instr_o, 32'h0050_0093);
    chk("t1_pc",    if_pc_o, 32'h0);
    chk("t1_npc",   if_next_pc_o, 32'h4);
    step();
    chk("t1_new_off", {31'd0, if_new_instr_o}, 32'd0);
    chk("t1_cnt",     if_fetch_count_o, 32'd1);
    step();
    chk("t1_req2",  {31'd0, imem_req_o}, 32'd1);
    chk("t1_addr2", imem_addr_o, 32'h4);

    // Delayed gnt and rvalid, decode busy for 5 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req_hold",  {31'd0, imem_req_o}, 32'd1);
      chk("t2_addr_hold", imem_addr_o, 32'h4);
    end
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2_no_new", {31'd0, if_new_instr_o}, 32'd0);
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0113;
    step();
    imem_rvalid_i = 1'b0;
    chk("t2_new",   {31'd0, if_new_instr_o}, 32'd1);
    chk("t2_instr", if_instr_o, 32'h00A0_0113);
    chk("t2_pc",    if_pc_o, 32'h4);
    dec_stage_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_noreq", {31'd0, imem_req_o}, 32'd0);
      chk("t2_hold_nonew", {31'd0, if_new_instr_o}, 32'd0);
    end
    chk("t2_cnt", if_fetch_count_o, 32'd2);
    dec_stage_busy_i = 1'b0;
    step();
    chk("t2_req3",  {31'd0, imem_req_o}, 32'd1);
    chk("t2_addr3", imem_addr_o, 32'h8);

    // Redirect during HOLD
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0033;
    step();
    imem_rvalid_i = 1'b0; dec_stage_busy_i = 1'b1;
    step();
    if_branch_taken_i = 1'b1; if_branch_target_i = 32'h100;
    step();
    if_branch_taken_i = 1'b0; dec_stage_busy_i = 1'b0;
    chk("t3_hold_noreq", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("t3_addr_100", imem_addr_o, 32'h100);
    chk("t3_pc_kept",  if_pc_o, 32'h8);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111;
    step();
    imem_rvalid_i = 1'b0;
    chk("t3_pc_100", if_pc_o, 32'h100);
    step();
    if_branch_taken_i = 1'b1; if_branch_target_i = 32'h203;
    step();
    if_branch_taken_i = 1'b0;
    chk("t3_req_200",  {31'd0, imem_req_o}, 32'd1);
    chk("t3_addr_200", imem_addr_o, 32'h200);

    // Redirect while in WAIT: data dropped
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0; if_branch_taken_i = 1'b1; if_branch_target_i = 32'h40;
    step();
    if_branch_taken_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    step();
    imem_rvalid_i = 1'b0;
    chk("t4_no_new",  {31'd0, if_new_instr_o}, 32'd0);
    chk("t4_req",     {31'd0, imem_req_o}, 32'd1);
    chk("t4_addr_40", imem_addr_o, 32'h40);
    chk("t4_cnt",     if_fetch_count_o, 32'd4);
    chk("t4_instr",   if_instr_o, 32'h1111_1111);

    // PC wrap at top of address space
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
    step();
    imem_rvalid_i = 1'b0;
    chk("t5_pc_40", if_pc_o, 32'h40);
    step();
    if_branch_taken_i = 1'b1; if_branch_target_i = 32'hFFFF_FFFC;
    step();
    if_branch_taken_i = 1'b0;
    chk("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_3333;
    step();
    imem_rvalid_i = 1'b0;
    chk("t5_pc_top",  if_pc_o, 32'hFFFF_FFFC);
    chk("t5_npc_wrap", if_next_pc_o, 32'h0);
    step();
    chk("t5_cnt", if_fetch_count_o, 32'd6);
    step();
    chk("t5_addr_wrap", imem_addr_o, 32'h0);

    // Reset during WAIT with late rvalid
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0; rst = 1'b1;
    step();
    chk("t6_req",   {31'd0, imem_req_o}, 32'd0);
    chk("t6_busy",  {31'd0, if_stage_busy_o}, 32'd0);
    chk("t6_pc",    if_pc_o, 32'h0);
    chk("t6_cnt",   if_fetch_count_o, 32'd0);
    chk("t6_instr", if_instr_o, 32'h0000_0013);
    rst = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem_rvalid_i = 1'b0;
    chk("t6_no_new",  {31'd0, if_new_instr_o}, 32'd0);
    chk("t6_instr2",  if_instr_o, 32'h0000_0013);
    wait_req(4);
    chk("t6_refetch", imem_addr_o, 32'h0);
    chk("t6_no_new2", {31'd0, if_new_instr_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
